mem_latency_model: RTL

MEM_LATENCY_MODEL -- requirements
Module: mem_latency_model

---
 rtl/mem_latency_pkg.sv | 27 ++
 rtl/mem_req_fifo.sv | 54 +++++
 rtl/mem_latency_model.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_latency_pkg.sv
// mem_latency_pkg: request record, head FSM states and jitter LFSR constants
// shared by the memory latency model and its request queue.
`default_nettype none

package mem_latency_pkg;

    localparam int unsigned MAX_LINE_WORDS = 16;
    localparam int unsigned WDATA_W        = MAX_LINE_WORDS * 32;

    localparam logic [7:0] LFSR_SEED     = 8'hA5;
    // Taps 8,6,5,4 counted from 1 at the LSB
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

    typedef struct packed {
        logic               we;
        logic [31:0]        addr;
        logic [WDATA_W-1:0] wdata;
    } mem_req_s;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } head_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: circular request buffer with explicit occupancy count; exposes
// the head entry and the entry behind it so the next head is visible at pop.
`default_nettype none

module mem_req_fifo
    import mem_latency_pkg::*;
#(
    parameter int  depth_p = 2,
    localparam int CNT_W   = $clog2(depth_p + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  mem_req_s         push_data,
    input  logic             pop,
    output mem_req_s         head,
    output mem_req_s         second,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int PTR_W = (depth_p > 1) ? $clog2(depth_p) : 1;

    mem_req_s         entries [depth_p];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (nreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_data;
    end

    assign head   = entries[rd_ptr];
    assign second = entries[bump(rd_ptr)];
    assign full   = (count == CNT_W'(depth_p));

endmodule

`default_nettype wire

// File: rtl/mem_latency_model.sv
// mem_latency_model: fixed-latency in-order line memory behind a small request
// queue. Optional macro MEM_LATENCY_JITTER_EN adds 0-3 LFSR-driven extra cycles.
`default_nettype none

module mem_latency_model
    import mem_latency_pkg::*;
#(
    parameter int    els_p            = 2048,
    parameter int    dma_data_width_p = 4,
    parameter int    latency_p        = 4,
    parameter int    queue_depth_p    = 2,
    parameter string init_file_p      = ""
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic                            mem_valid_i,
    output logic                            mem_ready_o,
    input  logic                            mem_we_i,
    input  logic [31:0]                     mem_addr_i,
    input  logic [dma_data_width_p*32-1:0]  mem_wdata_i,
    output logic                            mem_valid_o,
    output logic [dma_data_width_p*32-1:0]  mem_data_o
);

    localparam int LINE_W = dma_data_width_p * 32;
    localparam int IDX_W  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int SHIFT  = 2 + $clog2(dma_data_width_p);
    localparam int CNT_W  = $clog2(queue_depth_p + 1);

    mem_req_s          req_in, head, second, fire_head;
    logic [CNT_W-1:0]  count;
    logic              full, accept, pop, start, fire, fwd;
    head_state_e       state, state_next;
    logic [8:0]        timer, svc, svc_start;
    logic              valid_q;
    logic [LINE_W-1:0] data_q;
    logic [IDX_W-1:0]  head_idx, fire_idx;
    logic [LINE_W-1:0] mem [els_p];

    function automatic logic [IDX_W-1:0] line_index(input logic [31:0] a);
        return IDX_W'((a >> SHIFT) % 32'(els_p));
    endfunction

    assign mem_ready_o = ~full & ~nreset;
    assign accept      = mem_valid_i & mem_ready_o;
    assign pop         = valid_q;
    assign req_in      = '{we: mem_we_i, addr: mem_addr_i, wdata: WDATA_W'(mem_wdata_i)};

    mem_req_fifo #(
        .depth_p (queue_depth_p)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (accept),
        .push_data (req_in),
        .pop       (pop),
        .head      (head),
        .second    (second),
        .count     (count),
        .full      (full)
    );

    // A new head appears on an accept into an empty queue or on a pop that leaves work behind
    always_comb begin
        start = 1'b0;
        if (pop) start = (count > CNT_W'(1)) || accept;
        else     start = (count == '0) && accept;
    end

    assign fire_head = !start ? head : ((pop && count > CNT_W'(1)) ? second : req_in);
    assign head_idx  = line_index(head.addr);
    assign fire_idx  = line_index(fire_head.addr);
    assign fwd       = pop && head.we && (head_idx == fire_idx);

`ifdef MEM_LATENCY_JITTER_EN
    logic [7:0] lfsr;
    logic [8:0] svc_q;

    always_ff @(posedge clk) begin
        if (nreset) begin
            lfsr  <= LFSR_SEED;
            svc_q <= 9'(latency_p);
        end else begin
            if (pop)   lfsr  <= {lfsr[6:0], ^(lfsr & LFSR_TAP_MASK)};
            if (start) svc_q <= svc_start;
        end
    end

    assign svc_start = 9'(latency_p) + 9'(lfsr[1:0]);
    assign svc       = svc_q;
`else
    assign svc_start = 9'(latency_p);
    assign svc       = 9'(latency_p);
`endif

    assign fire = start ? (svc_start == 9'd1)
                        : (state == BUSY && !valid_q && (timer + 9'd1 == svc));

    always_ff @(posedge clk) begin
        if (nreset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (pop && count == CNT_W'(1) && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            timer   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= fire;
            if (start)                        timer <= 9'd1;
            else if (state == BUSY && !valid_q) timer <= timer + 9'd1;
            if (fire) data_q <= fire_head.we ? '0
                              : (fwd ? head.wdata[LINE_W-1:0] : mem[fire_idx]);
        end
    end

    // Array survives reset; a write lands only when its completion closes
    always_ff @(posedge clk) begin
        if (!nreset && pop && head.we) mem[head_idx] <= head.wdata[LINE_W-1:0];
    end

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^(head.wdata >> LINE_W) ^ ^(fire_head.wdata >> LINE_W);

    assign mem_valid_o = valid_q;
    assign mem_data_o  = data_q;

endmodule

`default_nettype wire
